// File: rtl/pc_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings and the step alignment helper.
package pc_pkg;

    localparam int unsigned NPC_OP_W = 3;

    // Any code other than NPC_PLUS4 redirects the PC to the supplied target.
    typedef enum logic [NPC_OP_W-1:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JR     = 3'b011
    } npc_op_e;

    // Number of low address bits that must be zero for a STEP-aligned fetch.
    function automatic int unsigned step_shift(input int unsigned step);
        return $clog2(step);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that remembers a redirect target that arrived while fetch was stalled.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] target_o,
    output logic            valid_o
);

    logic [XLEN-1:0] target_q, target_d;
    logic            valid_q, valid_d;

    // Clear wins over load; a new load simply overwrites an older target.
    always_comb begin
        target_d = target_q;
        valid_d  = valid_q;
        if (clear_i) begin
            target_d = '0;
            valid_d  = 1'b0;
        end else if (load_i) begin
            target_d = target_i;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign target_o = target_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential step, redirects, trap entry/return and a
// stall-tolerant pending-redirect buffer. All outputs come straight from registers.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_1000,
    parameter int unsigned      STEP         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [NPC_OP_W-1:0] npc_op,
    input  logic [XLEN-1:0]     npc,
    input  logic                trap,
    input  logic [XLEN-1:0]     trap_epc,
    input  logic                eret,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     epc,
    output logic                redirected,
    output logic                pend_valid
);

    localparam int unsigned     STEP_SH    = step_shift(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << STEP_SH) - XLEN'(1));
    localparam logic [XLEN-1:0] RESET_PC   = RESET_VECTOR & ALIGN_MASK;
    localparam logic [XLEN-1:0] TRAP_PC    = TRAP_VECTOR & ALIGN_MASK;
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            redir_q, redir_d;
    logic            buf_load, buf_clear;
    logic [XLEN-1:0] pend_target;
    logic            pend_valid_w;
    logic            is_redirect;
    logic [XLEN-1:0] npc_aligned;

    assign is_redirect = (npc_op != NPC_PLUS4);
    assign npc_aligned = npc & ALIGN_MASK;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (buf_load),
        .clear_i  (buf_clear),
        .target_i (npc_aligned),
        .target_o (pend_target),
        .valid_o  (pend_valid_w)
    );

    // Priority: trap > eret > stall (buffer any redirect) > live redirect > pending > step.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        redir_d   = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (trap) begin
            pc_d      = TRAP_PC;
            epc_d     = trap_epc & ALIGN_MASK;
            buf_clear = 1'b1;
            redir_d   = 1'b1;
        end else if (eret) begin
            pc_d      = epc_q;
            buf_clear = 1'b1;
            redir_d   = 1'b1;
        end else if (stall) begin
            buf_load = is_redirect;
        end else if (is_redirect) begin
            pc_d      = npc_aligned;
            buf_clear = 1'b1;
            redir_d   = 1'b1;
        end else if (pend_valid_w) begin
            pc_d      = pend_target;
            buf_clear = 1'b1;
            redir_d   = 1'b1;
        end else begin
            pc_d = pc_q + STEP_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            redir_q <= redir_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign redirected = redir_q;
    assign pend_valid = pend_valid_w;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each driven cycle pushes its hand-derived expected outputs
// onto a scoreboard queue that a monitor pops and compares just after the clock edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic [31:0] npc = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_epc = '0;
    logic        eret = 1'b0;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        redirected;
    logic        pend_valid;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        red;
        logic        pv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_1000),
        .STEP         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .npc_op     (npc_op),
        .npc        (npc),
        .trap       (trap),
        .trap_epc   (trap_epc),
        .eret       (eret),
        .pc         (pc),
        .epc        (epc),
        .redirected (redirected),
        .pend_valid (pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the expectation describes outputs after the next rise.
    task automatic drive(input string tag, input logic r, input logic s, input logic [2:0] op,
                         input logic [31:0] n, input logic t, input logic [31:0] te,
                         input logic er, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic e_red, input logic e_pv);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; npc_op = op; npc = n;
        trap = t; trap_epc = te; eret = er;
        e.tag = tag; e.pc = e_pc; e.epc = e_epc; e.red = e_red; e.pv = e_pv;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            $display("[%0t] %-14s pc=0x%08h epc=0x%08h red=%0b pend=%0b",
                     $time, mon_e.tag, pc, epc, redirected, pend_valid);
            check({mon_e.tag, ".pc"},   pc,                 mon_e.pc);
            check({mon_e.tag, ".epc"},  epc,                mon_e.epc);
            check({mon_e.tag, ".red"},  32'(redirected),    32'(mon_e.red));
            check({mon_e.tag, ".pend"}, 32'(pend_valid),    32'(mon_e.pv));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        tag            rst stl op    npc            trp te            ert  pc             epc            red pv
        drive("reset0",        1, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,   0, 0);
        drive("reset1",        1, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,   0, 0);
        drive("seq4",          0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h4,         32'h0,   0, 0);
        drive("seq8",          0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h8,         32'h0,   0, 0);
        drive("seqC",          0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'hC,         32'h0,   0, 0);
        drive("seq10",         0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h10,        32'h0,   0, 0);
        drive("stall_redir",   0, 1, 3'd1, 32'h80,        0, 32'h0,        0, 32'h10,        32'h0,   0, 1);
        drive("stall_hold1",   0, 1, 3'd0, 32'h0,         0, 32'h0,        0, 32'h10,        32'h0,   0, 1);
        drive("stall_hold2",   0, 1, 3'd0, 32'h0,         0, 32'h0,        0, 32'h10,        32'h0,   0, 1);
        drive("release",       0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h80,        32'h0,   1, 0);
        drive("after_rel",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h84,        32'h0,   0, 0);
        drive("buf_80",        0, 1, 3'd1, 32'h80,        0, 32'h0,        0, 32'h84,        32'h0,   0, 1);
        drive("buf_90",        0, 1, 3'd2, 32'h90,        0, 32'h0,        0, 32'h84,        32'h0,   0, 1);
        drive("same_cyc_A0",   0, 0, 3'd3, 32'hA0,        0, 32'h0,        0, 32'hA0,        32'h0,   1, 0);
        drive("buf_dropped",   0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'hA4,        32'h0,   0, 0);
        drive("jump_40",       0, 0, 3'd2, 32'h40,        0, 32'h0,        0, 32'h40,        32'h0,   1, 0);
        drive("pend_80",       0, 1, 3'd1, 32'h80,        0, 32'h0,        0, 32'h40,        32'h0,   0, 1);
        drive("trap_stall",    0, 1, 3'd0, 32'h0,         1, 32'h44,       0, 32'h1000,      32'h44,  1, 0);
        drive("trap_step",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h1004,      32'h44,  0, 0);
        drive("eret",          0, 0, 3'd0, 32'h0,         0, 32'h0,        1, 32'h44,        32'h44,  1, 0);
        drive("eret_step",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h48,        32'h44,  0, 0);
        drive("trap_and_eret", 0, 0, 3'd0, 32'h0,         1, 32'h200,      1, 32'h1000,      32'h200, 1, 0);
        drive("eret2",         0, 0, 3'd0, 32'h0,         0, 32'h0,        1, 32'h200,       32'h200, 1, 0);
        drive("eret2_step",    0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h204,       32'h200, 0, 0);
        drive("npc_align",     0, 0, 3'd1, 32'h83,        0, 32'h0,        0, 32'h80,        32'h200, 1, 0);
        drive("epc_align",     0, 0, 3'd0, 32'h0,         1, 32'h107,      0, 32'h1000,      32'h104, 1, 0);
        drive("eret3",         0, 0, 3'd0, 32'h0,         0, 32'h0,        1, 32'h104,       32'h104, 1, 0);
        drive("to_top",        0, 0, 3'd1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h104, 1, 0);
        drive("wrap",          0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h104, 0, 0);
        drive("wrap_step",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h4,         32'h104, 0, 0);
        drive("pend_300",      0, 1, 3'd1, 32'h300,       0, 32'h0,        0, 32'h4,         32'h104, 0, 1);
        drive("rst_mid_stall", 1, 1, 3'd0, 32'h0,         0, 32'h0,        0, 32'h0,         32'h0,   0, 0);
        drive("post_rst0",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h4,         32'h0,   0, 0);
        drive("post_rst1",     0, 0, 3'd0, 32'h0,         0, 32'h0,        0, 32'h8,         32'h0,   0, 0);
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage; the next generation of the plain PC register. It adds a configurable width, reset vector and step, trap entry and return (`eret`) with an internal EPC register, and a pending-redirect buffer so a branch/jump redirect that arrives during a stall is not lost. It sits between the hazard/branch logic (`stall`, `npc_op`, `npc`) and instruction memory (`pc`).

## Interface
Parameters:
- `XLEN`, 32: address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_1000: PC loaded on trap.
- `STEP`, 4: sequential increment in bytes; power of two.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `stall`  in  1: hold PC; does not block trap or eret.
- `npc_op`  in  3: 3'b000 means sequential; any non-zero value means redirect to `npc`.
- `npc`  in  XLEN: redirect target.
- `trap`  in  1: exception entry, one-cycle pulse.
- `trap_epc`  in  XLEN: return address captured on trap.
- `eret`  in  1: return from trap, one-cycle pulse.
- `pc`  out  XLEN: current fetch address (registered).
- `epc`  out  XLEN: saved exception PC (registered).
- `redirected`  out  1: high for one cycle after `pc` was loaded from a non-sequential source.
- `pend_valid`  out  1: a buffered redirect is waiting.

## Operation
- Alignment: `npc`, `trap_epc`, `TRAP_VECTOR` and `RESET_VECTOR` have their low log2(`STEP`) bits forced to 0 before use.
- Sequential step: `pc + STEP` modulo 2^XLEN. Wrap-around from the top address to 0 is legal and silent.
- Per-edge priority, highest first:
  1. `rst`
  2. `trap`: `pc`←TRAP_VECTOR, `epc`←`trap_epc`, pending cleared.
  3. `eret`: `pc`←`epc`, pending cleared.
  4. `stall`=1 with `npc_op`≠0: PC holds; pending←`npc`, `pend_valid`←1. A later redirect during the same stall overwrites the buffer (latest wins).
  5. `stall`=1 otherwise: PC and pending hold.
  6. `stall`=0 with `npc_op`≠0: `pc`←`npc`, pending cleared. A same-cycle redirect beats the buffered one.
  7. `stall`=0 with `pend_valid`=1: `pc`←pending target, pending cleared.
  8. Otherwise `pc`←`pc+STEP`.
- `trap` and `eret` together: the trap is taken and `eret` is ignored.
- `epc` changes only on trap. It persists across `eret`.
- `redirected` is registered. It is 1 in the cycle following any load from cases 2, 3, 6 or 7, and 0 otherwise.

## Timing
- Reset values: `pc`=RESET_VECTOR (aligned), `epc`=0, `pend_valid`=0, pending target=0, `redirected`=0.
- `rst` overrides every other input on the same edge. Asserting reset while a redirect is pending discards that redirect.
- Latency: every input takes effect at the next rising edge. `pc` is visible one cycle after the cause.
- Stall release: the buffered target appears on `pc` at the first edge where `stall`=0.
- No combinational path from any input to any output.

## Structure
- Shared package `pc_pkg` holds the `npc_op` encodings (`NPC_PLUS4`=3'b000 plus the existing branch/jump/jr codes) and the `STEP` alignment helper. These must stay consistent with the central control-encoding definitions.
- Sub-module `pc_redirect_buf` holds the pending target plus its valid bit, with load, clear and hold controls. The top level keeps the priority mux, the PC register, the EPC register and the `redirected` flag.

## Test plan
- Reset: hold `rst` for 2 cycles and release. Expect `pc`=0x0, then 0x4 and 0x8 on successive edges, with `redirected`=0 throughout.
- Stalled redirect: at `pc`=0x10 drive `stall`=1 for 3 cycles with `npc_op`=3'b001, `npc`=0x80 in the first stall cycle only. Expect `pc` held at 0x10 and `pend_valid`=1. After release expect `pc`=0x80, `redirected`=1 for one cycle, and `pend_valid`=0.
- Overwrite and same-cycle win: during a stall, buffer 0x80 then 0x90. Release with a simultaneous `npc`=0xA0. Expect `pc`=0xA0 and the buffer cleared.
- Trap during stall: at `pc`=0x40 with `stall`=1 and a pending 0x80, pulse `trap` with `trap_epc`=0x44. Expect `pc`=0x1000, `epc`=0x44, `pend_valid`=0. Then pulse `eret`: expect `pc`=0x44.
- Edge cases:
  - `trap` and `eret` in the same cycle: the trap wins.
  - `npc`=0x83: expect `pc`=0x80 (aligned).
  - `pc`=0xFFFF_FFFC stepping: expect `pc`=0x0.
- Reset mid-stall with a pending redirect: expect `pc`=RESET_VECTOR and `pend_valid`=0. The old target never appears on `pc`.
